fifo_rd_sched: RTL and testbench

Read-domain scheduler that shares the async FIFO read port among up to 4 rclk-domain consumers. It arbitrates bursts round-robin, drives rinc, and registers the popped data into a one-deep output stage tagged with the owner id. It sits between the FIFO read-pointer logic (rinc/rempty/rdata) and the consumer blocks.

---
 rtl/fifo_rd_sched.sv | 171 +++++++++++++++++
 tb/tb_fifo_rd_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_sched.sv
// Round-robin read-port scheduler for an async FIFO with a registered, id-tagged one-deep output stage.
// Optional empty-stall burst abort: define FIFO_RD_SCHED_TIMEOUT_EN.
module fifo_rd_sched #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                     rclk,
  input  logic                     rrst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     rempty,
  input  logic [DATA_WIDTH-1:0]    rdata,
  output logic                     rinc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [1:0]               out_id,
  output logic                     out_last,
  output logic                     burst_abort
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [LEN_W:0] ONE = 1;

  state_t             state, state_nxt;
  logic [1:0]         rr_ptr, cur_id, pick_id, cand;
  logic               pick_valid;
  logic [LEN_W:0]     remaining;
  logic [LEN_W-1:0]   pick_len;
  logic [3:0]         req_pad, pick_oh;
  logic [4*LEN_W-1:0] len_pad;
  logic               grant_now, last_pop;

`ifdef FIFO_RD_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] stall_cnt;
  logic            timeout_hit, abort_now;
`endif

  // Requester vectors padded to the 4-slot maximum so indexing stays width-exact.
  always_comb begin
    req_pad = '0;
    req_pad[NUM_REQ-1:0] = req;
    len_pad = '0;
    len_pad[NUM_REQ*LEN_W-1:0] = req_len;
  end

  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 2'((32'(rr_ptr) + i) % NUM_REQ);
      if (!pick_valid && req_pad[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
    pick_oh = 4'b0001 << pick_id;
  end

  always_comb begin
    case (pick_id)
      2'd0:    pick_len = len_pad[0*LEN_W +: LEN_W];
      2'd1:    pick_len = len_pad[1*LEN_W +: LEN_W];
      2'd2:    pick_len = len_pad[2*LEN_W +: LEN_W];
      default: pick_len = len_pad[3*LEN_W +: LEN_W];
    endcase
  end

  assign rinc = (state == XFER) && !rempty && (!out_valid || out_ready);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_now = 1'b0;
    last_pop  = 1'b0;
`ifdef FIFO_RD_SCHED_TIMEOUT_EN
    abort_now = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_now = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (rinc && remaining == ONE) begin
          last_pop  = 1'b1;
          state_nxt = IDLE;
        end
`ifdef FIFO_RD_SCHED_TIMEOUT_EN
        else if (timeout_hit) begin
          abort_now = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      gnt       <= '0;
      cur_id    <= '0;
      rr_ptr    <= 2'(NUM_REQ - 1);
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else begin
      if (grant_now) begin
        gnt       <= pick_oh[NUM_REQ-1:0];
        cur_id    <= pick_id;
        remaining <= {1'b0, pick_len} + ONE;
      end
      if (rinc) remaining <= remaining - ONE;
      if (last_pop) begin
        gnt    <= '0;
        rr_ptr <= cur_id;
      end
`ifdef FIFO_RD_SCHED_TIMEOUT_EN
      if (abort_now) begin
        gnt       <= '0;
        rr_ptr    <= cur_id;
        remaining <= '0;
      end
`endif
      // Output stage drains on its own; it may still hold the last word after the FSM moves on.
      if (rinc) begin
        out_data  <= rdata;
        out_valid <= 1'b1;
        out_id    <= cur_id;
        out_last  <= (remaining == ONE);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef FIFO_RD_SCHED_TIMEOUT_EN
  assign timeout_hit = (state == XFER) && rempty && (stall_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      stall_cnt   <= '0;
      burst_abort <= 1'b0;
    end else begin
      burst_abort <= abort_now;
      if (grant_now || rinc || abort_now)   stall_cnt <= '0;
      else if (state == XFER && rempty)     stall_cnt <= stall_cnt + TO_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign burst_abort    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Bench for fifo_rd_sched: FIFO/consumer environment, transaction-level round-robin model and scoreboard.
module tb_fifo_rd_sched;
  localparam int NUM_REQ     = 2;
  localparam int DW          = 8;
  localparam int LEN_W       = 4;
  localparam int TIMEOUT_CYC = 16;

  logic                     rclk = 1'b0;
  logic                     rrst_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       gnt;
  logic                     rempty;
  logic [DW-1:0]            rdata;
  logic                     rinc;
  logic                     out_valid;
  logic                     out_ready;
  logic [DW-1:0]            out_data;
  logic [1:0]               out_id;
  logic                     out_last;
  logic                     burst_abort;

  fifo_rd_sched #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .LEN_W      (LEN_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .req        (req),
    .req_len    (req_len),
    .gnt        (gnt),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_last   (out_last),
    .burst_abort(burst_abort)
  );

  always #5 rclk = ~rclk;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          pops = 0;
  int          last_owner;
  bit          hold_empty = 1'b0;
  logic [DW-1:0] fifo_q[$];
  word_t       exp_out[$];
  int          exp_pop_id[$];
  int          pop_cyc[$];

  logic               s_rinc, s_ov, s_last, s_abort, rinc_s;
  logic [NUM_REQ-1:0] s_gnt;
  logic [DW-1:0]      s_data;
  logic               bp_prev = 1'b0;
  word_t              bp_word;

  function automatic int next_owner(int last, logic [NUM_REQ-1:0] mask);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (last + k) % NUM_REQ;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic add_word(int o, logic [DW-1:0] d, logic last, bit to_fifo);
    word_t w;
    w.id = 2'(o); w.data = d; w.last = last;
    exp_out.push_back(w);
    exp_pop_id.push_back(o);
    if (to_fifo) fifo_q.push_back(d);
  endtask

  task automatic plan_burst(logic [NUM_REQ-1:0] mask, int len);
    int o;
    o = next_owner(last_owner, mask);
    last_owner = o;
    for (int w = 0; w <= len; w++) add_word(o, DW'($urandom), (w == len), 1'b1);
  endtask

  task automatic step();
    logic [NUM_REQ-1:0] oh;
    word_t e, got;
    int o;
    rempty = hold_empty || (fifo_q.size() == 0);
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    @(negedge rclk);
    cyc++;
    if (cyc > 40000) begin
      $display("FAIL cycle_budget: got %0d cycles required < 40000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    s_rinc = rinc; s_ov = out_valid; s_last = out_last; s_gnt = gnt; s_data = out_data; s_abort = burst_abort;
    vectors++;
    if (rinc && rempty) begin
      miscompares++; $display("FAIL pop_when_empty: got rinc=1 required 0 at cycle %0d", cyc);
    end
    if (rinc === 1'b1) begin
      pop_cyc.push_back(cyc);
      vectors++;
      if (exp_pop_id.size() == 0) begin
        miscompares++; $display("FAIL unexpected_pop: got rinc=1 required no pop at cycle %0d", cyc);
      end else begin
        o = exp_pop_id.pop_front();
        oh = '0; oh[o] = 1'b1;
        if (gnt !== oh) begin
          miscompares++; $display("FAIL pop_gnt: got %b required %b at cycle %0d", gnt, oh, cyc);
        end
      end
    end
    got = {out_id, out_data, out_last};
    if (bp_prev) begin
      vectors++;
      if (out_valid !== 1'b1 || got !== bp_word) begin
        miscompares++; $display("FAIL bp_stable: got v=%b %h required v=1 %h at cycle %0d", out_valid, got, bp_word, cyc);
      end
    end
    bp_prev = out_valid && !out_ready;
    bp_word = got;
    if (out_valid === 1'b1 && out_ready) begin
      vectors++;
      if (exp_out.size() == 0) begin
        miscompares++; $display("FAIL unexpected_word: got %h required none at cycle %0d", got, cyc);
      end else begin
        e = exp_out.pop_front();
        if (got !== e) begin
          miscompares++; $display("FAIL out_word: got id=%0d d=%h last=%b required id=%0d d=%h last=%b", out_id, out_data, out_last, e.id, e.data, e.last);
        end
      end
    end
`ifndef FIFO_RD_SCHED_TIMEOUT_EN
    vectors++;
    if (burst_abort !== 1'b0) begin
      miscompares++; $display("FAIL abort_tied: got %b required 0", burst_abort);
    end
`endif
    rinc_s = rinc;
    @(posedge rclk);
    #1;
    if (rinc_s === 1'b1 && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
  endtask

  task automatic drain(string name);
    for (int n = 0; n < 300 && exp_out.size() != 0; n++) step();
    vectors++;
    if (exp_out.size() != 0) begin
      miscompares++; $display("FAIL %s_drain: got %0d words pending required 0", name, exp_out.size());
    end
    step();
  endtask

  task automatic run_pops(int total, string name);
    for (int n = 0; n < 2000 && pops < total; n++) step();
    vectors++;
    if (pops != total) begin
      miscompares++; $display("FAIL %s_pops: got %0d required %0d", name, pops, total);
    end
  endtask

  task automatic test_reset();
    rrst_n = 1'b0; req = '0; req_len = '0; out_ready = 1'b0; rempty = 1'b1; rdata = '0;
    #12;
    vectors += 7;
    if (gnt !== '0)         begin miscompares++; $display("FAIL rst_gnt: got %b required 0", gnt); end
    if (rinc !== 1'b0)      begin miscompares++; $display("FAIL rst_rinc: got %b required 0", rinc); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b required 0", out_valid); end
    if (out_data !== '0)    begin miscompares++; $display("FAIL rst_data: got %h required 0", out_data); end
    if (out_id !== 2'd0)    begin miscompares++; $display("FAIL rst_id: got %0d required 0", out_id); end
    if (out_last !== 1'b0)  begin miscompares++; $display("FAIL rst_last: got %b required 0", out_last); end
    if (burst_abort !== 1'b0) begin miscompares++; $display("FAIL rst_abort: got %b required 0", burst_abort); end
    @(posedge rclk); #1;
    rrst_n = 1'b1;
    last_owner = NUM_REQ - 1;
    step();
  endtask

  task automatic test_single_burst();
    logic [NUM_REQ-1:0] tg[7];
    logic tr[7], tv[7], tl[7];
    logic [DW-1:0] td[7];
    logic [DW-1:0] a;
    last_owner = next_owner(last_owner, 2'b01);
    for (int w = 0; w < 4; w++) begin
      a = 8'hA0 + DW'(w);
      add_word(last_owner, a, (w == 3), 1'b1);
    end
    req = 2'b01; req_len = {4'd0, 4'd3}; out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step();
      if (c == 0) req = '0;
      tg[c] = s_gnt; tr[c] = s_rinc; tv[c] = s_ov; tl[c] = s_last; td[c] = s_data;
    end
    for (int c = 0; c < 7; c++) begin
      vectors += 3;
      if (tg[c] !== ((c >= 1 && c <= 4) ? 2'b01 : 2'b00)) begin miscompares++; $display("FAIL single_gnt c%0d: got %b", c, tg[c]); end
      if (tr[c] !== (c >= 1 && c <= 4)) begin miscompares++; $display("FAIL single_rinc c%0d: got %b", c, tr[c]); end
      if (tv[c] !== (c >= 2 && c <= 5)) begin miscompares++; $display("FAIL single_valid c%0d: got %b", c, tv[c]); end
      if (c >= 2 && c <= 5) begin
        a = 8'hA0 + DW'(c - 2);
        vectors += 2;
        if (td[c] !== a) begin miscompares++; $display("FAIL single_data c%0d: got %h required %h", c, td[c], a); end
        if (tl[c] !== (c == 5)) begin miscompares++; $display("FAIL single_last c%0d: got %b required %b", c, tl[c], (c == 5)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    pops = 0; pop_cyc.delete();
    for (int b = 0; b < 8; b++) plan_burst(2'b11, 0);
    req = 2'b11; req_len = '0; out_ready = 1'b1;
    run_pops(8, "b2b");
    req = '0;
    for (int i = 1; i < pop_cyc.size(); i++) begin
      vectors++;
      if (pop_cyc[i] - pop_cyc[i-1] != 2) begin
        miscompares++; $display("FAIL b2b_gap: got %0d cycles required 2", pop_cyc[i] - pop_cyc[i-1]);
      end
    end
    drain("b2b");
  endtask

  task automatic test_empty_stall();
    last_owner = next_owner(last_owner, 2'b01);
    add_word(last_owner, 8'h55, 1'b0, 1'b0);
    add_word(last_owner, 8'h66, 1'b1, 1'b0);
    req = 2'b01; req_len = {4'd0, 4'd1}; out_ready = 1'b1;
    step();
    req = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      vectors += 2;
      if (s_rinc !== 1'b0) begin miscompares++; $display("FAIL stall_rinc: got %b required 0", s_rinc); end
      if (s_gnt !== 2'b01) begin miscompares++; $display("FAIL stall_gnt: got %b required 01", s_gnt); end
    end
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'h66);
    drain("stall");
    vectors++;
    if (s_gnt !== '0) begin miscompares++; $display("FAIL stall_end_gnt: got %b required 0", s_gnt); end
  endtask

  task automatic test_backpressure();
    pops = 0;
    plan_burst(2'b10, 5);
    req = 2'b10; req_len = {4'd5, 4'd0}; out_ready = 1'b1;
    step();
    req = '0;
    step(); step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (s_rinc !== 1'b0) begin miscompares++; $display("FAIL bp_rinc: got %b required 0", s_rinc); end
    end
    out_ready = 1'b1;
    pop_cyc.delete();
    drain("bp");
    vectors += 2;
    if (pops != 6) begin miscompares++; $display("FAIL bp_pops: got %0d required 6", pops); end
    if (pop_cyc.size() != 4 || pop_cyc[3] - pop_cyc[0] != 3) begin
      miscompares++; $display("FAIL bp_rate: got %0d pops after resume required 4 consecutive", pop_cyc.size());
    end
  endtask

  task automatic test_reset_midburst();
    plan_burst(2'b01, 3);
    req = 2'b01; req_len = {4'd0, 4'd3}; out_ready = 1'b1;
    step();
    req = '0;
    step();
    rrst_n = 1'b0;
    #1;
    vectors += 5;
    if (gnt !== '0)         begin miscompares++; $display("FAIL mid_rst_gnt: got %b required 0", gnt); end
    if (rinc !== 1'b0)      begin miscompares++; $display("FAIL mid_rst_rinc: got %b required 0", rinc); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b required 0", out_valid); end
    if (out_data !== '0)    begin miscompares++; $display("FAIL mid_rst_data: got %h required 0", out_data); end
    if (out_last !== 1'b0)  begin miscompares++; $display("FAIL mid_rst_last: got %b required 0", out_last); end
    fifo_q.delete(); exp_out.delete(); exp_pop_id.delete();
    bp_prev = 1'b0;
    last_owner = NUM_REQ - 1;
    step();
    rrst_n = 1'b1;
    pops = 0;
    plan_burst(2'b01, 3);
    req = 2'b01;
    step();
    req = '0;
    drain("mid_rst");
    vectors++;
    if (pops != 4) begin miscompares++; $display("FAIL mid_rst_pops: got %0d required 4", pops); end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] mask;
    int lens[NUM_REQ];
    int k, total;
    for (int seg = 0; seg < 6; seg++) begin
      mask = NUM_REQ'($urandom_range(1, 3));
      for (int i = 0; i < NUM_REQ; i++) begin
        lens[i] = $urandom_range(0, 15);
        req_len[i*LEN_W +: LEN_W] = LEN_W'(lens[i]);
      end
      k = $urandom_range(2, 5);
      total = 0;
      for (int b = 0; b < k; b++) begin
        int o;
        o = next_owner(last_owner, mask);
        total += lens[o] + 1;
        plan_burst(mask, lens[o]);
      end
      pops = 0;
      req = mask;
      for (int n = 0; n < 2000 && pops < total; n++) begin
        out_ready  = ($urandom_range(0, 3) != 0);
        hold_empty = ($urandom_range(0, 4) == 0);
        step();
      end
      req = '0;
      hold_empty = 1'b0;
      vectors++;
      if (pops != total) begin miscompares++; $display("FAIL rand_pops seg%0d: got %0d required %0d", seg, pops, total); end
      out_ready = 1'b1;
      drain("rand");
    end
  endtask

`ifdef FIFO_RD_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int seen, at;
    pops = 0;
    last_owner = next_owner(last_owner, 2'b01);
    add_word(last_owner, 8'h11, 1'b0, 1'b1);
    add_word(last_owner, 8'h22, 1'b0, 1'b1);
    void'(exp_pop_id.pop_back());
    exp_pop_id.push_back(last_owner);
    req = 2'b01; req_len = {4'd0, 4'd3}; out_ready = 1'b1;
    step();
    req = '0;
    run_pops(2, "to");
    seen = 0; at = -1;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (s_abort === 1'b1) begin
        seen++; at = n;
        vectors++;
        if (s_gnt !== '0) begin miscompares++; $display("FAIL to_gnt: got %b required 0", s_gnt); end
      end
    end
    vectors += 2;
    if (seen != 1) begin miscompares++; $display("FAIL to_pulses: got %0d required 1", seen); end
    if (at != TIMEOUT_CYC + 1) begin miscompares++; $display("FAIL to_when: got %0d required %0d", at, TIMEOUT_CYC + 1); end
    plan_burst(2'b10, 0);
    req = 2'b10;
    step();
    req = '0;
    drain("to_next");
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_empty_stall();
    test_backpressure();
    test_reset_midburst();
    test_random();
`ifdef FIFO_RD_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
